// File: rtl/tone_pkg.sv
// Shared types, note table and helpers for the tone arbiter.
package tone_pkg;

    typedef enum logic [1:0] {IDLE, PLAY, SWITCH, STOP} t_arb_state;

    localparam int C_HP_W   = 18;
    localparam int C_NOTE_W = 3;

    // Hold length in clk cycles for a given clock and duration.
    function automatic int hold_cycles(input int clk_frq, input int hold_ms);
        return clk_frq / 1000 * hold_ms;
    endfunction

    // Half-period in clk cycles of one octave C4..C5, rounded to nearest.
    function automatic logic [C_HP_W-1:0] half_period(input real clk_frq, input int note_idx);
        real f;
        case (note_idx)
            0:       f = 261.63;
            1:       f = 293.66;
            2:       f = 329.63;
            3:       f = 349.23;
            4:       f = 392.00;
            5:       f = 440.00;
            6:       f = 493.88;
            default: f = 523.25;
        endcase
        return C_HP_W'($rtoi(clk_frq / (2.0 * f) + 0.5));
    endfunction

    // {found, index} of the highest set bit.
    function automatic logic [C_NOTE_W:0] msb_idx(input logic [7:0] v);
        logic [C_NOTE_W:0] r;
        r = '0;
        for (int i = 0; i < 8; i++) begin
            if (v[i]) r = {1'b1, C_NOTE_W'(i)};
        end
        return r;
    endfunction

endpackage

// File: rtl/tone_arbiter_key_sync.sv
// Two-flop synchronizer for the raw key pins followed by a registered rising-edge detect.
module key_sync #(
    parameter int C_N = 8
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [C_N-1:0] keys,
    output logic [C_N-1:0] level,
    output logic [C_N-1:0] rise
);

    logic [C_N-1:0] meta;
    logic [C_N-1:0] sync;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta  <= '0;
            sync  <= '0;
            level <= '0;
            rise  <= '0;
        end else begin
            meta  <= keys;
            sync  <= meta;
            level <= sync;
            rise  <= sync & ~level;
        end
    end

endmodule

// File: rtl/tone_arbiter.sv
// Last-pressed-key arbiter for a shared square-wave tone generator; pitch changes
// and stops are applied only on generator edges so the waveform has no runt pulses.
module tone_arbiter
    import tone_pkg::*;
#(
    parameter int C_CLK_FRQ = 100_000_000,
    parameter int C_N_KEYS  = 8,
    parameter int C_HOLD_MS = 20,
    parameter int C_WDOG    = 262_144
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [C_N_KEYS-1:0] keys,
    input  logic                i_edge,
    input  logic                i_level,
    output logic                o_en,
    output logic [C_HP_W-1:0]   o_half_period,
    output logic [C_NOTE_W-1:0] o_note,
    output logic                o_active
);

    localparam int C_HOLD_CNT = hold_cycles(C_CLK_FRQ, C_HOLD_MS);
    localparam int C_HOLD_W   = $clog2(C_HOLD_CNT + 1);
    localparam int C_WD_W     = $clog2(C_WDOG + 1);

    logic [C_N_KEYS-1:0] key_lvl;
    logic [C_N_KEYS-1:0] key_rise;

    key_sync #(.C_N(C_N_KEYS)) u_key_sync (
        .clk   (clk),
        .rst   (rst),
        .keys  (keys),
        .level (key_lvl),
        .rise  (key_rise)
    );

    logic [C_HP_W-1:0] hp_tab [8];

    for (genvar g = 0; g < 8; g++) begin : g_hp
        localparam logic [C_HP_W-1:0] C_HP = half_period(real'(C_CLK_FRQ), g);
        assign hp_tab[g] = C_HP;
    end

    // Request tracking: new press wins, release of the winner falls back to the highest held key.
    logic [C_NOTE_W-1:0] req_q;
    logic                req_vld_q;
    logic [C_NOTE_W-1:0] req_idx;
    logic                req_vld;
    logic [C_NOTE_W:0]   rise_top;
    logic [C_NOTE_W:0]   held_top;

    always_comb begin
        req_idx  = req_q;
        req_vld  = req_vld_q;
        rise_top = msb_idx(key_rise);
        held_top = msb_idx(key_lvl);
        if (rise_top[C_NOTE_W]) begin
            req_vld = 1'b1;
            req_idx = rise_top[C_NOTE_W-1:0];
        end else if (!req_vld_q || !key_lvl[req_q]) begin
            req_vld = held_top[C_NOTE_W];
            req_idx = held_top[C_NOTE_W-1:0];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            req_q     <= '0;
            req_vld_q <= 1'b0;
        end else begin
            req_q     <= req_idx;
            req_vld_q <= req_vld;
        end
    end

    t_arb_state          state;
    t_arb_state          state_nxt;
    logic                do_load;
    logic                do_off;
    logic [C_HOLD_W-1:0] hold_cnt;
    logic                hold_done;
    logic [C_WD_W-1:0]   wd_cnt;
    logic                wd_to;

    assign hold_done = (hold_cnt == C_HOLD_W'(C_HOLD_CNT));
    assign wd_to     = (wd_cnt == C_WD_W'(C_WDOG - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        do_load   = 1'b0;
        do_off    = 1'b0;
        case (state)
            IDLE: begin
                if (req_vld) begin
                    state_nxt = PLAY;
                    do_load   = 1'b1;
                end
            end
            PLAY: begin
                if (hold_done) begin
                    if (!req_vld) begin
                        state_nxt = STOP;
                    end else if (req_idx != o_note) begin
                        state_nxt = SWITCH;
                    end
                end
            end
            SWITCH: begin
                if (!req_vld) begin
                    state_nxt = STOP;
                end else if (req_idx == o_note) begin
                    state_nxt = PLAY;
                end else if (i_edge || wd_to) begin
                    state_nxt = PLAY;
                    do_load   = 1'b1;
                end
            end
            STOP: begin
                // A fresh request keeps the generator running and re-pitches on its next edge.
                if (req_vld) begin
                    state_nxt = SWITCH;
                end else if ((i_edge && !i_level) || wd_to) begin
                    state_nxt = IDLE;
                    do_off    = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    logic                en_nxt;
    logic [C_HP_W-1:0]   hp_nxt;
    logic [C_NOTE_W-1:0] note_nxt;
    logic                act_nxt;

    always_comb begin
        en_nxt   = o_en;
        hp_nxt   = o_half_period;
        note_nxt = o_note;
        if (do_load) begin
            en_nxt   = 1'b1;
            hp_nxt   = hp_tab[req_idx];
            note_nxt = req_idx;
        end
        if (do_off) begin
            en_nxt = 1'b0;
        end
        act_nxt = (state_nxt == PLAY) || (state_nxt == SWITCH);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            o_en          <= 1'b0;
            o_half_period <= '0;
            o_note        <= '0;
            o_active      <= 1'b0;
        end else begin
            o_en          <= en_nxt;
            o_half_period <= hp_nxt;
            o_note        <= note_nxt;
            o_active      <= act_nxt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold_cnt <= '0;
        end else if (do_load) begin
            hold_cnt <= '0;
        end else if (!hold_done) begin
            hold_cnt <= hold_cnt + 1'b1;
        end
    end

    // Watchdog restarts on every state change and only runs while waiting for an edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wd_cnt <= '0;
        end else if ((state_nxt != state) || !((state == SWITCH) || (state == STOP))) begin
            wd_cnt <= '0;
        end else if (!wd_to) begin
            wd_cnt <= wd_cnt + 1'b1;
        end
    end

endmodule

// File: doc/tone_arbiter.md
Name: tone_arbiter

Overview:
- Shares one square-wave tone generator between C_N_KEYS keyboard keys.
- Selects the winning key (last pressed), loads that key's half-period into the generator and enforces a minimum note duration.
- Changes pitch and stops only on generator output edges, so the audio waveform never has runt pulses.
- Sits between the key input pins and the tone generator in the keyboard top level.

Parameters:
- C_CLK_FRQ, 100_000_000, main clock frequency [Hz].
- C_N_KEYS, 8, number of keys; fixed to 8 (one octave, C4..C5).
- C_HOLD_MS, 20, minimum note duration [ms]; hold count = C_CLK_FRQ/1000*C_HOLD_MS.
- C_WDOG, 262_144, clock cycles to wait for a generator edge before forcing an update.

Ports:
- clk  in  1  main clock.
- rst  in  1  reset; asynchronous, active-high.
- keys  in  C_N_KEYS  raw key levels, asynchronous, 1 = pressed.
- i_edge  in  1  generator strobe; one-cycle pulse in the cycle its output toggles.
- i_level  in  1  generator output level after the toggle flagged by i_edge.
- o_en  out  1  generator enable.
- o_half_period  out  18  generator half-period in clk cycles.
- o_note  out  3  index of the sounding key.
- o_active  out  1  high while a note sounds (PLAY or SWITCH).

Behaviour:
- Reset (async, any state): all outputs 0; FSM = IDLE; synchronizers, press history and counters cleared.
- Input path: keys pass through a 2-FF synchronizer, then a registered rising-edge detect. A key event is visible to the FSM 3 cycles after the pin changes.
- Winner selection:
  - A newly pressed key becomes the request.
  - Simultaneous rises: the highest index wins.
  - If the requested key is released, the request falls back to the highest-index key still held.
  - No key held: request = none.
- Half-period table (package): round(C_CLK_FRQ / (2*f)). At 100 MHz: C4 191110, D4 170265, E4 151685, F4 143172, G4 127551, A4 113636, B4 101239, C5 95557.
- States:
  - IDLE:
    - o_en = 0.
    - On request: load o_half_period and o_note, set o_en = 1 in the next cycle, start the hold counter, go to PLAY.
    - Latency: 4 clk from pin to o_en.
  - PLAY:
    - Request differs from o_note and hold expired → SWITCH.
    - Request = none and hold expired → STOP.
    - Changes arriving before hold expiry are deferred, not dropped; the latest request is evaluated at expiry.
  - SWITCH:
    - Wait for i_edge. In that cycle, update o_half_period and o_note to the request, restart hold, go to PLAY.
    - If the request has become none, go to STOP instead.
    - If the request returns to o_note before the edge, go to PLAY with no update.
  - STOP:
    - Wait for i_edge with i_level = 0, then drop o_en in the same cycle and go to IDLE.
    - A new request arriving in STOP → SWITCH, which keeps the tone going gap-free.
- Watchdog: in SWITCH or STOP, no qualifying i_edge within C_WDOG cycles forces the update (SWITCH) or o_en = 0 (STOP).
- Rules:
  - o_half_period is constant whenever o_en = 1, except in i_edge cycles.
  - Hold counter saturates at its terminal value.
  - All outputs are registered.

Decomposition:
- Package tone_pkg contains:
  - state enum t_arb_state {IDLE, PLAY, SWITCH, STOP};
  - C_HP_W = 18;
  - function half_period(clk_frq, note_idx) with the note frequency table in Hz (real);
  - localparam hold-count width derived via $clog2.
- One sub-module, key_sync: a C_N_KEYS-wide 2-FF synchronizer with rising-edge detect.

Test Plan (100 MHz, C_HOLD_MS = 1 → 100_000 cycles; bench model of the generator toggles on o_half_period):
- Reset released, keys = 0 → o_en, o_active, o_note, o_half_period all 0 indefinitely.
- Press key 5 at t0 → o_en = 1 at t0+4 clk, o_half_period = 113636, o_note = 5; measured output period 227272 clk.
- Hold key 0, then press key 7 at 20_000 cycles → switch deferred to hold expiry, applied on the next i_edge; o_half_period = 95557; no output phase shorter than 95557.
- Press keys 2 and 4 in the same cycle → o_note = 4; release 4 after hold → switches to note 2 (151685) on the next edge.
- Release all keys while i_level = 1 → o_en stays 1 until the falling edge, then 0; the final output level is 0.
- Assert rst mid-SWITCH → outputs 0 in the same cycle (async); after release with a key held, the block restarts from IDLE. With i_edge tied low, a forced STOP occurs C_WDOG cycles after entering STOP.
